// File: rtl/neuron_stream_driver_if.sv
// Byte-wide valid/ready stream from the chip pins into neuron_stream_driver.
// The master drives bytes; the slave (the driver) reports when it can take one.
interface neuron_stream_driver_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/neuron_stream_driver.sv
// Command/payload byte decoder that loads a neuron_lif's weights, inputs and
// parameters atomically, runs it for N timesteps and counts the spikes it emits.
module neuron_stream_driver #(
  parameter int SYNAPSES       = 32,
  parameter int THRESHOLD_BITS = $clog2(SYNAPSES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  neuron_stream_driver_if.slave     stream,
  output logic [SYNAPSES-1:0]       weights,
  output logic [SYNAPSES-1:0]       inputs,
  output logic [2:0]                shift,
  output logic [3:0]                batchnorm_factor,
  output logic [THRESHOLD_BITS-1:0] threshold,
  output logic                      neuron_enable,
  output logic                      neuron_reset,
  input  logic                      neuron_spike,
  output logic [7:0]                spike_count,
  output logic                      busy,
  output logic                      cmd_error
);

  localparam int NBYTES   = SYNAPSES / 8;
  // PARAMS needs two bytes of shadow even when SYNAPSES is only 8.
  localparam int SHADOW_W = (SYNAPSES < 16) ? 16 : SYNAPSES;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  localparam logic [7:0] OP_WEIGHTS = 8'h01;
  localparam logic [7:0] OP_INPUTS  = 8'h02;
  localparam logic [7:0] OP_PARAMS  = 8'h03;
  localparam logic [7:0] OP_RUN     = 8'h04;
  localparam logic [7:0] OP_CLEAR   = 8'h05;

  logic [1:0]          state;
  logic [7:0]          opcode;
  logic [3:0]          byte_cnt;
  logic [SHADOW_W-1:0] shadow;
  logic [7:0]          run_left;

  logic                accept;
  logic [3:0]          payload_len;
  logic                last_byte;
  logic [SHADOW_W-1:0] shadow_next;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    busy              = (state == S_RUN);
    neuron_enable     = busy;
    stream.data_ready = !reset && !busy;
    accept            = stream.data_valid && stream.data_ready;

    payload_len = 4'd1;
    case (opcode)
      OP_WEIGHTS, OP_INPUTS: payload_len = 4'(NBYTES);
      OP_PARAMS:             payload_len = 4'd2;
      default:               payload_len = 4'd1;
    endcase
    last_byte = (byte_cnt == payload_len - 4'd1);

    // Shadow with the byte on the bus merged in: the value a commit publishes.
    shadow_next = shadow;
    shadow_next[int'(byte_cnt) * 8 +: 8] = stream.data_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      opcode           <= 8'h00;
      byte_cnt         <= 4'd0;
      // NOTE: the shadow is cleared too, so a payload cut off by reset can
      // never leak into a later commit.
      shadow           <= '0;
      run_left         <= 8'd0;
      weights          <= '0;
      inputs           <= '0;
      shift            <= 3'd0;
      batchnorm_factor <= 4'b0100;
      threshold        <= '0;
      neuron_reset     <= 1'b0;
      spike_count      <= 8'd0;
      cmd_error        <= 1'b0;
    end else begin
      neuron_reset <= 1'b0;
      if (neuron_enable && neuron_spike && spike_count != 8'hFF)
        spike_count <= spike_count + 8'd1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (stream.data_in)
              OP_WEIGHTS, OP_INPUTS, OP_PARAMS, OP_RUN: begin
                opcode   <= stream.data_in;
                byte_cnt <= 4'd0;
                state    <= S_PAYLOAD;
              end
              OP_CLEAR: neuron_reset <= 1'b1;
              default:  cmd_error    <= 1'b1;
            endcase
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            shadow   <= shadow_next;
            byte_cnt <= byte_cnt + 4'd1;
            if (last_byte) begin
              state <= S_IDLE;
              case (opcode)
                OP_WEIGHTS: weights <= shadow_next[SYNAPSES-1:0];
                OP_INPUTS:  inputs  <= shadow_next[SYNAPSES-1:0];
                OP_PARAMS: begin
                  shift            <= shadow_next[2:0];
                  batchnorm_factor <= shadow_next[6:3];
                  threshold        <= stream.data_in[THRESHOLD_BITS-1:0];
                end
                OP_RUN: begin
                  spike_count <= 8'd0;
                  run_left    <= stream.data_in;
                  if (stream.data_in != 8'd0)
                    state <= S_RUN;
                end
                default: ;
              endcase
            end
          end
        end

        S_RUN: begin
          run_left <= run_left - 8'd1;
          if (run_left == 8'd1)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_stream_driver.sv
// Self-checking bench for neuron_stream_driver: randomized command streams and
// spike patterns checked against a command-level model of the driver.
module tb_neuron_stream_driver;
  localparam int SYNAPSES = 32;
  localparam int TBITS    = $clog2(SYNAPSES) + 1;
  localparam int NBYTES   = SYNAPSES / 8;
  localparam int VW       = 2 * SYNAPSES + 3 + 4 + TBITS + 1 + 8;
  localparam int GUARD    = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  neuron_stream_driver_if bus ();

  logic [SYNAPSES-1:0] weights, inputs;
  logic [2:0]          shift;
  logic [3:0]          batchnorm_factor;
  logic [TBITS-1:0]    threshold;
  logic                neuron_enable, neuron_reset, neuron_spike, busy, cmd_error;
  logic [7:0]          spike_count;

  neuron_stream_driver #(.SYNAPSES(SYNAPSES)) dut (
    .clk              (clk),
    .reset            (reset),
    .stream           (bus.slave),
    .weights          (weights),
    .inputs           (inputs),
    .shift            (shift),
    .batchnorm_factor (batchnorm_factor),
    .threshold        (threshold),
    .neuron_enable    (neuron_enable),
    .neuron_reset     (neuron_reset),
    .neuron_spike     (neuron_spike),
    .spike_count      (spike_count),
    .busy             (busy),
    .cmd_error        (cmd_error)
  );

  int vectors = 0;
  int miscompares = 0;

  // Command-level reference model of everything the driver exposes.
  logic [SYNAPSES-1:0] m_weights, m_inputs;
  logic [2:0]          m_shift;
  logic [3:0]          m_bn;
  logic [TBITS-1:0]    m_thr;
  logic                m_err;
  int                  m_count;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {weights, inputs, shift, batchnorm_factor, threshold, cmd_error, spike_count};

  function automatic logic [VW-1:0] model_vec();
    return {m_weights, m_inputs, m_shift, m_bn, m_thr, m_err, 8'(m_count)};
  endfunction

  task automatic model_reset();
    m_weights = '0; m_inputs = '0; m_shift = 3'd0; m_bn = 4'b0100;
    m_thr = '0; m_err = 1'b0; m_count = 0;
  endtask

  task automatic model_command(input logic [7:0] op, input logic [63:0] pl);
    case (op)
      8'h01: for (int k = 0; k < NBYTES; k++) m_weights[8*k +: 8] = pl[8*k +: 8];
      8'h02: for (int k = 0; k < NBYTES; k++) m_inputs[8*k +: 8] = pl[8*k +: 8];
      8'h03: begin
        m_shift = pl[2:0];
        m_bn    = pl[6:3];
        m_thr   = pl[8 +: TBITS];
      end
      8'h04: m_count = 0;
      8'h05: ;
      default: m_err = 1'b1;
    endcase
  endtask

  function automatic int payload_bytes(input logic [7:0] op);
    case (op)
      8'h01, 8'h02: return NBYTES;
      8'h03:        return 2;
      8'h04:        return 1;
      default:      return 0;
    endcase
  endfunction

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (bus.data_ready !== 1'b1 && guard < GUARD) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= GUARD) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: data_ready stayed %b, required 1 within %0d cycles", bus.data_ready, GUARD);
    end
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'($urandom);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [63:0] pl);
    send_byte(op);
    for (int k = 0; k < payload_bytes(op); k++) send_byte(pl[8*k +: 8]);
    model_command(op, pl);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.data_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== model_vec() || {neuron_enable, neuron_reset, busy, bus.data_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state: got vec=%h en/rst/busy/rdy=%b, required vec=%h en/rst/busy/rdy=0000",
               dut_vec, {neuron_enable, neuron_reset, busy, bus.data_ready}, model_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.data_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_weights();
    logic [7:0] bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(8'h01);
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k]);
      if (k < 3) begin
        vectors++;
        if (weights !== m_weights) begin
          miscompares++;
          $display("FAIL weights_partial byte%0d: got %h, required %h", k, weights, m_weights);
        end
      end
    end
    model_command(8'h01, 64'hDEAD_BEEF);
    vectors++;
    if (dut_vec !== model_vec() || weights !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL weights_commit: got %h, required %h", weights, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_params();
    send_cmd(8'h03, 64'h052D);
    vectors++;
    if ({shift, batchnorm_factor, threshold} !== {3'd5, 4'b0101, 6'd5} || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL params: got shift=%0d bn=%b thr=%0d, required shift=5 bn=0101 thr=5",
               shift, batchnorm_factor, threshold);
    end
  endtask

  task automatic test_random_cmds();
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  op;
      logic [63:0] pl = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h05;
        default: op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
      endcase
      send_cmd(op, pl);
      vectors++;
      if (dut_vec !== model_vec() || neuron_reset !== (op == 8'h05)) begin
        miscompares++;
        $display("FAIL random_cmd %0d op=%h: got vec=%h nrst=%b, required vec=%h nrst=%b",
                 i, op, dut_vec, neuron_reset, model_vec(), op == 8'h05);
      end
    end
  endtask

  // RUN N with either random or constant-high spikes from the stub neuron.
  task automatic do_run(input logic [7:0] n, input bit always_spike);
    send_cmd(8'h04, {56'd0, n});
    vectors++;
    if (spike_count !== 8'd0 || busy !== (n != 0)) begin
      miscompares++;
      $display("FAIL run_start n=%0d: got count=%0d busy=%b, required count=0 busy=%b", n, spike_count, busy, n != 0);
    end
    for (int i = 0; i < int'(n) + 3; i++) begin
      logic exp_en, spk;
      @(negedge clk);
      exp_en = (i < int'(n));
      vectors++;
      if (neuron_enable !== exp_en || busy !== exp_en || bus.data_ready !== !exp_en || spike_count !== 8'(m_count)) begin
        miscompares++;
        $display("FAIL run n=%0d cycle %0d: got en=%b busy=%b rdy=%b count=%0d, required en=%b busy=%b rdy=%b count=%0d",
                 n, i, neuron_enable, busy, bus.data_ready, spike_count, exp_en, exp_en, !exp_en, m_count);
      end
      spk = always_spike ? 1'b1 : 1'($urandom_range(0, 1));
      neuron_spike = spk;
      if (exp_en && spk && m_count < 255) m_count++;
    end
    neuron_spike = 1'b0;
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL run_end n=%0d: got %h, required %h", n, dut_vec, model_vec());
    end
  endtask

  task automatic test_run();
    send_cmd(8'h01, {32'd0, 32'hFFFF_FFFF});
    send_cmd(8'h02, {32'd0, 32'hFFFF_FFFF});
    send_cmd(8'h03, {48'd0, 8'h02, 8'h20});
    do_run(8'd10, 1'b0);
    do_run(8'($urandom_range(1, 20)), 1'b0);
    do_run(8'd1, 1'b1);
  endtask

  task automatic test_saturation();
    do_run(8'hFF, 1'b1);
    vectors++;
    if (spike_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: got %0d, required 255", spike_count);
    end
    do_run(8'h00, 1'b1);
  endtask

  task automatic test_error_clear();
    send_cmd(8'h7A, 64'd0);
    vectors++;
    if (cmd_error !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_error_set: got %b, required 1", cmd_error);
    end
    send_cmd(8'h05, 64'd0);
    vectors++;
    if (neuron_reset !== 1'b1 || cmd_error !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_pulse: got nrst=%b err=%b, required nrst=1 err=1", neuron_reset, cmd_error);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (neuron_reset !== 1'b0 || cmd_error !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_single_cycle: got nrst=%b err=%b, required nrst=0 err=1", neuron_reset, cmd_error);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_payload();
    logic [63:0] pl = {32'd0, $urandom};
    send_cmd(8'h02, {32'd0, $urandom | 32'h1});
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'hA5);
    apply_reset();
    send_cmd(8'h01, pl);
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL after_payload_reset: got %h, required %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    send_cmd(8'h04, 64'd8);
    neuron_spike = 1'b1;
    repeat (3) @(negedge clk);
    apply_reset();
    neuron_spike = 1'b0;
    vectors++;
    if (neuron_enable !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL run_reset: got en=%b busy=%b, required en=0 busy=0", neuron_enable, busy);
    end
    send_cmd(8'h03, {48'd0, 8'h03, 8'h7F});
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL after_run_reset: got %h, required %h", dut_vec, model_vec());
    end
  endtask

  initial begin
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    neuron_spike   = 1'b0;
    model_reset();
    test_reset();
    test_weights();
    test_params();
    test_random_cmds();
    test_run();
    test_saturation();
    test_error_clear();
    test_reset_mid_payload();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/neuron_stream_driver.md
Name: neuron_stream_driver

Overview:
Byte-stream front end that drives one neuron_lif instance. It takes a command/payload byte stream over a valid/ready handshake and assembles the SYNAPSES-wide weight and input vectors plus the shift, batchnorm_factor and threshold parameters. It issues neuron_enable pulses for a requested number of timesteps and counts the resulting spikes. It sits between the chip's 8-bit pin interface and neuron_lif.

Parameters:
SYNAPSES, 32, neuron fan-in; must be a multiple of 8, range 8..64
THRESHOLD_BITS, $clog2(SYNAPSES)+1, threshold width; must be <= 8

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_in  in  8  command/payload byte
data_valid  in  1  data_in is valid
data_ready  out  1  block can accept a byte
weights  out  SYNAPSES  registered weight vector to neuron
inputs  out  SYNAPSES  registered input spike vector to neuron
shift  out  3  decay shift to neuron
batchnorm_factor  out  4  BN scale to neuron
threshold  out  THRESHOLD_BITS  firing threshold to neuron
neuron_enable  out  1  one timestep per high cycle
neuron_reset  out  1  one-cycle membrane clear pulse
neuron_spike  in  1  is_spike from neuron
spike_count  out  8  spikes counted in the last/ongoing run, saturating
busy  out  1  RUN in progress
cmd_error  out  1  sticky: unknown opcode seen

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: weights=0, inputs=0, shift=0, batchnorm_factor=4'b0100 (scale 1), threshold=0, spike_count=0, neuron_enable=0, neuron_reset=0, busy=0, cmd_error=0, data_ready=0 during the reset cycle and 1 on the first cycle after reset deasserts.
- Handshake: a byte is accepted on a rising edge where data_valid && data_ready. data_valid may be held across cycles; each accepted byte is consumed exactly once. data_ready never depends combinationally on data_valid.
- Opcodes (first byte in IDLE):
  - 0x01 WEIGHTS: followed by SYNAPSES/8 payload bytes.
  - 0x02 INPUTS: followed by SYNAPSES/8 payload bytes.
  - 0x03 PARAMS: followed by 2 payload bytes.
  - 0x04 RUN: followed by 1 byte N.
  - 0x05 CLEAR: no payload.
  - Any other value: ignored, sets cmd_error, stays in IDLE.
- Byte order: little-endian. Payload byte k fills bits [8k+7:8k].
- PARAMS byte0 packing: [2:0]=shift, [6:3]=batchnorm_factor, [7] ignored.
- PARAMS byte1 packing: [THRESHOLD_BITS-1:0]=threshold, upper bits ignored.
- Atomic commit: payload bytes go into a shadow register. The visible output vector/params update on the same edge that accepts the final payload byte, so the neuron never sees a partial update.
- States:
  - IDLE: data_ready=1. Opcode decode.
  - PAYLOAD: data_ready=1. Byte counter runs 0..len-1. On the last byte: commit and go to IDLE.
  - RUN: data_ready=0, busy=1.
- RUN timing: when N is accepted at edge t:
  - spike_count clears at edge t.
  - N>0: neuron_enable is high for exactly N cycles, starting the cycle after t. busy is high over the same N cycles. The block returns to IDLE with data_ready=1 on the cycle after the last enable cycle.
  - N=0: no enable, stays in IDLE, spike_count still clears.
- Spike counting: spike_count increments on each edge where neuron_enable && neuron_spike, and saturates at 255. It holds its value after the run until the next RUN or reset.
- CLEAR: neuron_reset is high for exactly the one cycle after the opcode edge. Next state is IDLE, ready for a new opcode in that same cycle.
- Reset mid-payload: shadow contents are discarded; outputs return to reset values.
- Reset mid-run: neuron_enable is 0 on the next cycle; counter and FSM return to reset values.
- Outputs are changed only by committed commands or by reset; data_valid toggling has no other effect.

Test Plan:
- Reset, then send 0x01,0xEF,0xBE,0xAD,0xDE -> weights stays 0 until the edge accepting 0xDE, then weights=0xDEADBEEF. No intermediate value is visible.
- Send 0x03,0x2D,0x05 -> shift=5, batchnorm_factor=4'b0101, threshold=5.
- Load weights=inputs=0xFFFFFFFF, threshold=2, send 0x04,0x0A -> neuron_enable high for exactly 10 consecutive cycles, busy matches, data_ready=0 during the run. spike_count equals the number of enable cycles with neuron_spike=1.
- Stub neuron_spike=1 constantly, RUN N=0xFF then N=0x00 -> after the first run spike_count=255 (saturating); after N=0 spike_count=0 with no enable pulse.
- Send 0x7A -> cmd_error=1 and sticky; the next 0x05 produces a single-cycle neuron_reset. cmd_error clears only on reset.
- Assert reset after 2 of 4 WEIGHTS payload bytes, and separately at cycle 3 of a RUN of 8 -> all outputs return to reset values on the next edge, neuron_enable drops immediately, and the next opcode is decoded correctly.
